// File: rtl/count_up_timer.sv
// Count-up timer: latch a 4-bit target, count inc pulses up to it, flag done/full.
// Optional build macro COUNT_UP_TIMER_AUTO_RELOAD_EN makes the counter free-run with period = target.
module count_up_timer #(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              latch,
    input  logic              inc,
    output logic [DATA_W-1:0] count,
    output logic              full,
    output logic              done,
    output logic              running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              done_q, done_d;

    // True when the increment about to be applied lands exactly on the target.
    function automatic logic hits_target(input logic [DATA_W-1:0] cnt,
                                         input logic [DATA_W-1:0] tgt);
        logic [DATA_W-1:0] nxt;
        nxt = cnt + DATA_W'(1);
        return (nxt == tgt);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        done_d   = 1'b0;
        if (latch) begin
            // Latch wins over inc; a zero target is already reached.
            target_d = in;
            count_d  = '0;
            if (in == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: count_d = '0;
                RUN: begin
                    if (inc) begin
                        if (hits_target(count_q, target_q)) begin
                            done_d = 1'b1;
`ifdef COUNT_UP_TIMER_AUTO_RELOAD_EN
                            count_d = '0;
`else
                            count_d = target_q;
                            state_d = DONE;
`endif
                        end else begin
                            count_d = count_q + DATA_W'(1);
                        end
                    end
                end
                DONE: ;
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        count   = count_q;
        done    = done_q;
        full    = (state_q == DONE);
        running = (state_q == RUN);
    end

endmodule

// File: tb/tb_count_up_timer.sv
// Self-checking bench for count_up_timer: directed vector table, multi-cycle sequences,
// and randomized traffic against an arithmetic reference model.
module tb_count_up_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       latch = 1'b0;
    logic       inc   = 1'b0;
    logic [3:0] in    = 4'd0;
    logic [3:0] count;
    logic       full, done, running;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       r;
        logic       l;
        logic       i;
        logic [3:0] d;
        logic [3:0] c;
        logic       f;
        logic       dn;
        logic       run;
    } vec_t;

    vec_t tbl[$];

    // Reference model: target and number of accepted increments since the last latch.
    bit m_act;
    int m_tgt;
    int m_n;
    bit m_dp;

    count_up_timer dut (
        .clock   (clock),
        .reset   (reset),
        .in      (in),
        .latch   (latch),
        .inc     (inc),
        .count   (count),
        .full    (full),
        .done    (done),
        .running (running)
    );

    always #5 clock = ~clock;

    task automatic model_step(input logic r, input logic l, input logic i, input logic [3:0] d);
        bit stopped;
`ifdef COUNT_UP_TIMER_AUTO_RELOAD_EN
        stopped = (m_tgt == 0);
`else
        stopped = (m_n >= m_tgt);
`endif
        m_dp = 1'b0;
        if (r) begin
            m_act = 1'b0;
            m_tgt = 0;
            m_n   = 0;
        end else if (l) begin
            m_act = 1'b1;
            m_tgt = int'(d);
            m_n   = 0;
            m_dp  = (d == 4'd0);
        end else if (m_act && i && !stopped) begin
            m_n = m_n + 1;
`ifdef COUNT_UP_TIMER_AUTO_RELOAD_EN
            m_dp = ((m_n % m_tgt) == 0);
`else
            m_dp = (m_n == m_tgt);
`endif
        end
    endtask

    task automatic model_expect(output logic [3:0] c, output logic f, output logic dn,
                                output logic run);
        dn = m_dp;
`ifdef COUNT_UP_TIMER_AUTO_RELOAD_EN
        c   = (m_act && m_tgt != 0) ? 4'(m_n % m_tgt) : 4'd0;
        f   = m_act && (m_tgt == 0);
        run = m_act && (m_tgt != 0);
`else
        c   = m_act ? 4'((m_n < m_tgt) ? m_n : m_tgt) : 4'd0;
        f   = m_act && (m_n >= m_tgt);
        run = m_act && (m_n < m_tgt);
`endif
    endtask

    task automatic apply(input logic r, input logic l, input logic i, input logic [3:0] d);
        @(negedge clock);
        reset = r;
        latch = l;
        inc   = i;
        in    = d;
        @(posedge clock);
        model_step(r, l, i, d);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] c, input logic f,
                         input logic dn, input logic run);
        vectors++;
        if ({count, full, done, running} !== {c, f, dn, run}) begin
            miscompares++;
            $display("FAIL %s: got count=%0d full=%0b done=%0b running=%0b, want count=%0d full=%0b done=%0b running=%0b",
                     nm, count, full, done, running, c, f, dn, run);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic i, input logic [3:0] d,
                       input logic [3:0] c, input logic f, input logic dn, input logic run);
        vec_t v;
        v.r = r; v.l = l; v.i = i; v.d = d;
        v.c = c; v.f = f; v.dn = dn; v.run = run;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] ec;
        logic       ef, ed, er;
        int         k;

        m_act = 0; m_tgt = 0; m_n = 0; m_dp = 0;

`ifndef COUNT_UP_TIMER_AUTO_RELOAD_EN
        //    r  l  i  in    count f  done run
        add(1, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        add(0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
        add(0, 1, 0, 4'd4, 4'd0, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd1, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd2, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd3, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd4, 1, 1, 0);
        add(0, 0, 1, 4'd0, 4'd4, 1, 0, 0);
        add(0, 0, 1, 4'd0, 4'd4, 1, 0, 0);
        add(0, 1, 0, 4'd0, 4'd0, 1, 1, 0);
        add(0, 0, 1, 4'd0, 4'd0, 1, 0, 0);
        add(0, 1, 0, 4'd6, 4'd0, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd1, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd2, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd3, 0, 0, 1);
        add(0, 1, 1, 4'd2, 4'd0, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd1, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd2, 1, 1, 0);
        add(0, 1, 0, 4'd9, 4'd0, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd1, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd2, 0, 0, 1);
        add(0, 0, 0, 4'd0, 4'd2, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd3, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd4, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd5, 0, 0, 1);
        add(1, 0, 1, 4'd0, 4'd0, 0, 0, 0);
        add(0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
        add(0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
        add(0, 1, 0, 4'd3, 4'd0, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd1, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd2, 0, 0, 1);
        add(0, 0, 1, 4'd0, 4'd3, 1, 1, 0);
        add(1, 1, 1, 4'd5, 4'd0, 0, 0, 0);
`else
        add(1, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        add(0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
        add(0, 1, 0, 4'd3, 4'd0, 0, 0, 1);
        for (int j = 0; j < 9; j++)
            add(0, 0, 1, 4'd0, 4'((j + 1) % 3), 0, ((j + 1) % 3) == 0, 1);
        add(0, 1, 0, 4'd0, 4'd0, 1, 1, 0);
        add(0, 0, 1, 4'd0, 4'd0, 1, 0, 0);
        add(1, 0, 0, 4'd0, 4'd0, 0, 0, 0);
`endif

        foreach (tbl[j]) begin
            apply(tbl[j].r, tbl[j].l, tbl[j].i, tbl[j].d);
            check($sformatf("table[%0d]", j), tbl[j].c, tbl[j].f, tbl[j].dn, tbl[j].run);
        end

`ifndef COUNT_UP_TIMER_AUTO_RELOAD_EN
        // Target 15 with inc toggling: count only moves on inc cycles, stops at 15.
        apply(1, 0, 0, 4'd0);
        apply(0, 1, 0, 4'd15);
        check("t15_latch", 4'd0, 0, 0, 1);
        k = 0;
        for (int j = 0; j < 40; j++) begin
            logic i;
            logic just;
            i = (j % 2) == 0;
            just = i && (k == 14);
            if (i && k < 15) k++;
            apply(0, 0, i, 4'd0);
            check($sformatf("t15_step%0d", j), 4'(k), k >= 15, just, k < 15);
        end
`endif

        // Randomized traffic against the model.
        apply(1, 0, 0, 4'd0);
        for (int j = 0; j < 3000; j++) begin
            logic       r, l, i;
            logic [3:0] d;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 9) == 0);
            i = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            apply(r, l, i, d);
            model_expect(ec, ef, ed, er);
            check($sformatf("rand%0d", j), ec, ef, ed, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
